dadder_dp_core: RTL and testbench



---
 rtl/dadder_dp_core.sv | 173 +++++++++++++++++
 tb/tb_dadder_dp_core.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dadder_dp_core.sv
// Digit-serial BCD adder/subtracter core: one digit per cycle, LSD first, sign-magnitude result.
// Optional build macro DADDER_DP_DIGIT_CHK_EN adds err_out and flags non-BCD operand digits.
module dadder_dp_core #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  vld_in,
    output logic                  rdy_in,
    input  logic                  op_in,
    input  logic [DATA_WIDTH-1:0] a_in,
    input  logic [DATA_WIDTH-1:0] b_in,
    output logic                  vld_out,
    output logic                  of_out,
    output logic [DATA_WIDTH-1:0] data_out
`ifdef DADDER_DP_DIGIT_CHK_EN
    ,
    output logic                  err_out
`endif
);

    localparam int unsigned NUM_DIGITS = DATA_WIDTH / 4;
    localparam int unsigned IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {IDLE, CALC, COMPL, OUT} state_t;

    state_t                  state, state_nxt;
    logic [DATA_WIDTH-1:0]   a_q, b_q, r_q, r_nxt;
    logic                    op_q, carry_q, carry_nxt;
    logic [IDX_W-1:0]        idx_q;
    logic                    accept, last_dig;
    logic [3:0]              opa, opb, dig;
    logic [4:0]              sum;
    logic                    rdy_d, vld_d, of_d;
    logic [DATA_WIDTH-1:0]   data_d;

    assign accept   = (state == IDLE) && vld_in && rdy_in;
    assign last_dig = (idx_q == LAST_IDX);

    // Operands and result are shift registers: digit 0 is always at [3:0], new digits enter at the top.
    always_comb begin
        opa = '0;
        opb = '0;
        if (state == COMPL) begin
            opb = 4'd9 - r_q[3:0];
        end else begin
            opa = a_q[3:0];
            opb = op_q ? (4'd9 - b_q[3:0]) : b_q[3:0];
        end
        sum = {1'b0, opa} + {1'b0, opb} + {4'b0000, carry_q};
        if (sum > 5'd9) begin
            dig       = 4'(sum - 5'd10);
            carry_nxt = 1'b1;
        end else begin
            dig       = sum[3:0];
            carry_nxt = 1'b0;
        end
        r_nxt = (r_q >> 4) | (DATA_WIDTH'(dig) << (DATA_WIDTH - 4));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (accept) state_nxt = CALC;
            CALC:  if (last_dig) state_nxt = (op_q && !carry_nxt) ? COMPL : OUT;
            COMPL: if (last_dig) state_nxt = OUT;
            OUT:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            op_q    <= 1'b0;
            carry_q <= 1'b0;
            idx_q   <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    a_q     <= a_in;
                    b_q     <= b_in;
                    op_q    <= op_in;
                    carry_q <= op_in;
                    idx_q   <= '0;
                    r_q     <= '0;
                end
                CALC: begin
                    a_q     <= a_q >> 4;
                    b_q     <= b_q >> 4;
                    r_q     <= r_nxt;
                    // Carry is preset for a possible ten's-complement pass; unused when going to OUT.
                    carry_q <= last_dig ? 1'b1 : carry_nxt;
                    idx_q   <= last_dig ? '0 : idx_q + 1'b1;
                end
                COMPL: begin
                    r_q     <= r_nxt;
                    carry_q <= carry_nxt;
                    idx_q   <= last_dig ? '0 : idx_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef DADDER_DP_DIGIT_CHK_EN
    logic illegal_q, err_d;

    function automatic logic has_bad_digit(input logic [DATA_WIDTH-1:0] v);
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (v[i*4 +: 4] > 4'd9) return 1'b1;
        end
        return 1'b0;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)    illegal_q <= 1'b0;
        else if (accept) illegal_q <= has_bad_digit(a_in) || has_bad_digit(b_in);
    end
`endif

    // Outputs are registered, so they are computed from the state being entered.
    always_comb begin
        rdy_d  = (state_nxt == IDLE);
        vld_d  = (state_nxt == OUT);
        data_d = data_out;
        of_d   = of_out;
        if (state_nxt == OUT) begin
            data_d = r_nxt;
            of_d   = (state == COMPL) ? 1'b1 : (op_q ? 1'b0 : carry_nxt);
        end
`ifdef DADDER_DP_DIGIT_CHK_EN
        err_d = err_out;
        if (state_nxt == OUT) begin
            err_d = illegal_q;
            if (illegal_q) begin
                data_d = '0;
                of_d   = 1'b0;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdy_in   <= 1'b0;
            vld_out  <= 1'b0;
            of_out   <= 1'b0;
            data_out <= '0;
        end else begin
            rdy_in   <= rdy_d;
            vld_out  <= vld_d;
            of_out   <= of_d;
            data_out <= data_d;
        end
    end

`ifdef DADDER_DP_DIGIT_CHK_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) err_out <= 1'b0;
        else          err_out <= err_d;
    end
`endif

endmodule

// File: tb/tb_dadder_dp_core.sv
// Self-checking bench for dadder_dp_core (DATA_WIDTH=32): vector table, random ops vs integer model, corner sequences.
module tb_dadder_dp_core;

    localparam int DW = 32;
    localparam int ND = DW / 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          vld_in;
    logic          rdy_in;
    logic          op_in;
    logic [DW-1:0] a_in, b_in;
    logic          vld_out;
    logic          of_out;
    logic [DW-1:0] data_out;
`ifdef DADDER_DP_DIGIT_CHK_EN
    logic          err_out;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    dadder_dp_core #(.DATA_WIDTH(DW)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .vld_in   (vld_in),
        .rdy_in   (rdy_in),
        .op_in    (op_in),
        .a_in     (a_in),
        .b_in     (b_in),
        .vld_out  (vld_out),
        .of_out   (of_out),
        .data_out (data_out)
`ifdef DADDER_DP_DIGIT_CHK_EN
        ,
        .err_out  (err_out)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string         name;
        logic          op;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] exp_data;
        logic          exp_of;
        logic          exp_err;
        int            exp_lat;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic longint bcd2int(input logic [DW-1:0] v);
        longint r = 0;
        longint p = 1;
        for (int i = 0; i < ND; i++) begin
            r += longint'(v[i*4 +: 4]) * p;
            p *= 10;
        end
        return r;
    endfunction

    function automatic logic [DW-1:0] int2bcd(input longint v);
        logic [DW-1:0] r = '0;
        for (int i = 0; i < ND; i++) begin
            r[i*4 +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic logic any_bad(input logic [DW-1:0] v);
        for (int i = 0; i < ND; i++) if (v[i*4 +: 4] > 4'd9) return 1'b1;
        return 1'b0;
    endfunction

    // Reference: plain integer arithmetic on decoded operands.
    task automatic model(input logic op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         output logic [DW-1:0] d, output logic of, output logic err, output int lat);
        longint da = bcd2int(a);
        longint db = bcd2int(b);
        longint m  = 1;
        for (int i = 0; i < ND; i++) m *= 10;
        err = 1'b0;
        lat = ND + 1;
        if (!op) begin
            d  = int2bcd((da + db) % m);
            of = (da + db) >= m;
        end else if (da >= db) begin
            d  = int2bcd(da - db);
            of = 1'b0;
        end else begin
            d   = int2bcd(db - da);
            of  = 1'b1;
            lat = 2 * ND + 1;
        end
        if (any_bad(a) || any_bad(b)) begin
            d   = '0;
            of  = 1'b0;
            err = 1'b1;
        end
    endtask

    task automatic run_op(input logic op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                          output logic [DW-1:0] d, output logic of, output logic err, output int lat);
        int w = 0;
        @(negedge clk);
        while (!rdy_in && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("rdy_wait", {63'd0, rdy_in}, 64'd1);
        op_in  = op;
        a_in   = a;
        b_in   = b;
        vld_in = 1'b1;
        @(posedge clk);
        @(negedge clk);
        vld_in = 1'b0;
        a_in   = $urandom;
        b_in   = $urandom;
        op_in  = 1'($urandom);
        lat = 1;
        while (!vld_out && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        d  = data_out;
        of = of_out;
`ifdef DADDER_DP_DIGIT_CHK_EN
        err = err_out;
`else
        err = 1'b0;
`endif
        @(negedge clk);
        chk("vld_pulse_len", {63'd0, vld_out}, 64'd0);
        chk("data_hold", {32'd0, data_out}, {32'd0, d});
    endtask

    initial begin
        logic [DW-1:0] d, ed, a, b;
        logic          of, eo, err, ee, op;
        int            lat, el, k;
        logic          saw_vld;

        reset_n = 1'b0;
        vld_in  = 1'b0;
        op_in   = 1'b0;
        a_in    = '0;
        b_in    = '0;

        vecs.push_back('{"add_25_17",   1'b0, 32'h00000025, 32'h00000017, 32'h00000042, 1'b0, 1'b0, 9});
        vecs.push_back('{"add_wrap",    1'b0, 32'h99999999, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 9});
        vecs.push_back('{"sub_pos",     1'b1, 32'h00000100, 32'h00000001, 32'h00000099, 1'b0, 1'b0, 9});
        vecs.push_back('{"sub_neg",     1'b1, 32'h00000001, 32'h00000100, 32'h00000099, 1'b1, 1'b0, 17});
        vecs.push_back('{"sub_equal",   1'b1, 32'h12345678, 32'h12345678, 32'h00000000, 1'b0, 1'b0, 9});
        vecs.push_back('{"add_no_cy",   1'b0, 32'h12345678, 32'h87654321, 32'h99999999, 1'b0, 1'b0, 9});
        vecs.push_back('{"add_top_cy",  1'b0, 32'h50000000, 32'h50000000, 32'h00000000, 1'b1, 1'b0, 9});
        vecs.push_back('{"sub_max_neg", 1'b1, 32'h00000000, 32'h99999999, 32'h99999999, 1'b1, 1'b0, 17});
`ifdef DADDER_DP_DIGIT_CHK_EN
        vecs.push_back('{"illegal_A",   1'b0, 32'h0000000A, 32'h00000001, 32'h00000000, 1'b0, 1'b1, 9});
        vecs.push_back('{"err_clear",   1'b0, 32'h00000001, 32'h00000001, 32'h00000002, 1'b0, 1'b0, 9});
`endif

        repeat (3) @(negedge clk);
        chk("rst_rdy",  {63'd0, rdy_in},  64'd0);
        chk("rst_vld",  {63'd0, vld_out}, 64'd0);
        chk("rst_of",   {63'd0, of_out},  64'd0);
        chk("rst_data", {32'd0, data_out}, 64'd0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rdy_after_rst", {63'd0, rdy_in}, 64'd1);

        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, d, of, err, lat);
            chk({vecs[i].name, "_data"}, {32'd0, d}, {32'd0, vecs[i].exp_data});
            chk({vecs[i].name, "_of"},   {63'd0, of}, {63'd0, vecs[i].exp_of});
            chk({vecs[i].name, "_lat"},  64'(lat), 64'(vecs[i].exp_lat));
`ifdef DADDER_DP_DIGIT_CHK_EN
            chk({vecs[i].name, "_err"},  {63'd0, err}, {63'd0, vecs[i].exp_err});
`endif
        end

        for (int n = 0; n < 40; n++) begin
            op = 1'($urandom);
            for (int i = 0; i < ND; i++) begin
                a[i*4 +: 4] = 4'($urandom_range(9, 0));
                b[i*4 +: 4] = 4'($urandom_range(9, 0));
            end
            if (n % 8 == 3) b = a;
            if (n % 8 == 5) a = 32'h99999999;
            model(op, a, b, ed, eo, ee, el);
            run_op(op, a, b, d, of, err, lat);
            chk("rnd_data", {32'd0, d}, {32'd0, ed});
            chk("rnd_of",   {63'd0, of}, {63'd0, eo});
            chk("rnd_lat",  64'(lat), 64'(el));
        end

        // vld_in held with changing operands while busy: only the first operands count.
        @(negedge clk);
        k = 0;
        while (!rdy_in && k < 50) begin
            @(negedge clk);
            k++;
        end
        op_in  = 1'b0;
        a_in   = 32'h00000123;
        b_in   = 32'h00000456;
        vld_in = 1'b1;
        @(posedge clk);
        k = 0;
        @(negedge clk);
        while (!vld_out && k < 40) begin
            chk("busy_rdy", {63'd0, rdy_in}, 64'd0);
            a_in  = $urandom;
            b_in  = $urandom;
            op_in = 1'($urandom);
            @(negedge clk);
            k++;
        end
        vld_in = 1'b0;
        chk("busy_vld_seen", {63'd0, vld_out}, 64'd1);
        chk("busy_rdy_out",  {63'd0, rdy_in},  64'd0);
        chk("busy_data", {32'd0, data_out}, 64'h579);
        chk("busy_of",   {63'd0, of_out},  64'd0);
        @(negedge clk);
        chk("busy_idle_gap", {63'd0, rdy_in}, 64'd1);

        // Abort mid-CALC: previous nonzero result must be cleared, no vld_out afterwards.
        run_op(1'b0, 32'h00000011, 32'h00000022, d, of, err, lat);
        chk("pre_abort_data", {32'd0, d}, 64'h33);
        op_in  = 1'b0;
        a_in   = 32'h99999999;
        b_in   = 32'h00000001;
        vld_in = 1'b1;
        @(posedge clk);
        @(negedge clk);
        vld_in = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("abort_vld",  {63'd0, vld_out}, 64'd0);
        chk("abort_of",   {63'd0, of_out},  64'd0);
        chk("abort_data", {32'd0, data_out}, 64'd0);
        chk("abort_rdy",  {63'd0, rdy_in},  64'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        saw_vld = 1'b0;
        @(negedge clk);
        chk("abort_rdy_release", {63'd0, rdy_in}, 64'd1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (vld_out) saw_vld = 1'b1;
        end
        chk("abort_no_vld", {63'd0, saw_vld}, 64'd0);
        chk("abort_data_hold", {32'd0, data_out}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
